// File: rtl/titan_rf_pkg.sv
// Shared register-file types and constants for the writeback path.
// Defines the default index/data widths, the link register index and the writeback source tag.
package titan_rf_pkg;

  localparam int REGBITS = 5;
  localparam int WIDTH   = 32;
  localparam int RA_REG  = 31;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_LINK = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue and cleared on load return.
// issue_stall is combinational off the registered vector, so a return releases decode one cycle later.
module wb_scoreboard #(
  parameter int REGBITS = titan_rf_pkg::REGBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  input  logic [REGBITS-1:0]    ld_dest,
  input  logic                  ld_issue,
  input  logic [REGBITS-1:0]    ld_issue_dest,
  input  logic [REGBITS-1:0]    rs,
  input  logic [REGBITS-1:0]    rt,
  output logic                  issue_stall,
  output logic [2**REGBITS-1:0] pending
);

  localparam int NREG = 2**REGBITS;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_nxt;
  logic            set_en;

  assign issue_stall = pend_q[rs] | pend_q[rt] | (ld_issue & pend_q[ld_issue_dest]);
  assign set_en      = ld_issue && !issue_stall && (ld_issue_dest != '0);

  // Set is applied after clear so a same-index issue and return leaves the bit set.
  always_comb begin
    pend_nxt = pend_q;
    if (ld_valid) pend_nxt[ld_dest] = 1'b0;
    if (set_en)   pend_nxt[ld_issue_dest] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end

  assign pending = pend_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates load/link/ALU writebacks onto the single register-file write port; one-cycle registered write.
// Loads are never stalled; link outranks ALU until the ALU has been denied STARVE_LIMIT cycles in a row.
module regfile_wb_arbiter
  import titan_rf_pkg::*;
#(
  parameter int REGBITS      = titan_rf_pkg::REGBITS,
  parameter int WIDTH        = titan_rf_pkg::WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  input  logic [REGBITS-1:0]    ld_dest,
  input  logic [WIDTH-1:0]      ld_data,
  input  logic                  link_valid,
  input  logic [WIDTH-1:0]      link_data,
  output logic                  link_ready,
  input  logic                  alu_valid,
  input  logic [REGBITS-1:0]    alu_dest,
  input  logic [WIDTH-1:0]      alu_data,
  output logic                  alu_ready,
  input  logic                  ld_issue,
  input  logic [REGBITS-1:0]    ld_issue_dest,
  input  logic [REGBITS-1:0]    Rs,
  input  logic [REGBITS-1:0]    Rt,
  output logic                  issue_stall,
  output logic                  regWriteEn,
  output logic [REGBITS-1:0]    Rdest,
  output logic [WIDTH-1:0]      writeData,
  output logic [2**REGBITS-1:0] pending
);

  localparam int                SCW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0]    LIMIT = SCW'(STARVE_LIMIT);
  localparam logic [REGBITS-1:0] RA   = REGBITS'(RA_REG);

  wb_src_t            src;
  logic [SCW-1:0]     starve_cnt;
  logic               alu_prio;
  logic [REGBITS-1:0] wb_dest;
  logic [WIDTH-1:0]   wb_data;

  assign alu_prio = (starve_cnt >= LIMIT);

  always_comb begin
    src = SRC_NONE;
    if (ld_valid)                                    src = SRC_LOAD;
    else if (alu_valid && (alu_prio || !link_valid)) src = SRC_ALU;
    else if (link_valid)                             src = SRC_LINK;
  end

  assign link_ready = (src == SRC_LINK);
  assign alu_ready  = (src == SRC_ALU);

  always_comb begin
    wb_dest = '0;
    wb_data = '0;
    case (src)
      SRC_LOAD: begin wb_dest = ld_dest;  wb_data = ld_data;   end
      SRC_LINK: begin wb_dest = RA;       wb_data = link_data; end
      SRC_ALU:  begin wb_dest = alu_dest; wb_data = alu_data;  end
      default:  begin wb_dest = '0;       wb_data = '0;        end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered so the file sees a stable port at its negedge write; r0 grants are swallowed here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteEn <= 1'b0;
      Rdest      <= '0;
      writeData  <= '0;
    end else begin
      regWriteEn <= (src != SRC_NONE) && (wb_dest != '0);
      if (src != SRC_NONE) begin
        Rdest     <= wb_dest;
        writeData <= wb_data;
      end
    end
  end

  wb_scoreboard #(.REGBITS(REGBITS)) u_sb (
    .clk           (clk),
    .reset         (reset),
    .ld_valid      (ld_valid),
    .ld_dest       (ld_dest),
    .ld_issue      (ld_issue),
    .ld_issue_dest (ld_issue_dest),
    .rs            (Rs),
    .rt            (Rt),
    .issue_stall   (issue_stall),
    .pending       (pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, starvation override, scoreboard stall, r0 and reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, link_valid, alu_valid, ld_issue;
  logic [4:0]  ld_dest, alu_dest, ld_issue_dest, Rs, Rt;
  logic [31:0] ld_data, link_data, alu_data;
  logic        link_ready, alu_ready, issue_stall, regWriteEn;
  logic [4:0]  Rdest;
  logic [31:0] writeData;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
    .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest), .Rs(Rs), .Rt(Rt),
    .issue_stall(issue_stall), .regWriteEn(regWriteEn), .Rdest(Rdest),
    .writeData(writeData), .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_dest = 0; ld_data = 0;
    link_valid = 0; link_data = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    ld_issue = 0; ld_issue_dest = 0; Rs = 0; Rt = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (2) tick();
    chk("rst_wen",   regWriteEn, 0);
    chk("rst_rdest", Rdest, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_pend",  pending, 0);
    chk("rst_stall", issue_stall, 0);
    reset = 1;
    tick();

    // Lone ALU write, one-cycle latency, single-cycle enable.
    alu_valid = 1; alu_dest = 5; alu_data = 32'h1234;
    #1 chk("alu_rdy", alu_ready, 1);
    tick(); alu_valid = 0;
    chk("alu_wen", regWriteEn, 1);
    chk("alu_rdest", Rdest, 5);
    chk("alu_wdata", writeData, 32'h1234);
    tick();
    chk("alu_wen_drop", regWriteEn, 0);

    // All three valid: load, then link, then ALU.
    ld_issue = 1; ld_issue_dest = 10;
    #1 chk("iss10_stall", issue_stall, 0);
    tick(); ld_issue = 0;
    chk("pend10", pending, 32'h400);
    ld_valid = 1; ld_dest = 10; ld_data = 32'hAA;
    link_valid = 1; link_data = 32'h400;
    alu_valid = 1; alu_dest = 6; alu_data = 32'h66;
    #1 chk("tri_link_rdy", link_ready, 0);
    chk("tri_alu_rdy", alu_ready, 0);
    tick(); ld_valid = 0;
    chk("tri_ld_rdest", Rdest, 10);
    chk("tri_ld_wdata", writeData, 32'hAA);
    chk("tri_pend", pending, 0);
    #1 chk("tri2_link_rdy", link_ready, 1);
    chk("tri2_alu_rdy", alu_ready, 0);
    tick(); link_valid = 0;
    chk("tri_link_rdest", Rdest, 31);
    chk("tri_link_wdata", writeData, 32'h400);
    #1 chk("tri3_alu_rdy", alu_ready, 1);
    tick(); alu_valid = 0;
    chk("tri_alu_rdest", Rdest, 6);
    chk("tri_alu_wdata", writeData, 32'h66);

    // Six back-to-back load returns, then starvation lets ALU past link.
    for (int i = 0; i < 6; i++) begin
      ld_issue = 1; ld_issue_dest = 5'(11 + i);
      tick();
    end
    ld_issue = 0;
    chk("pend_6ld", pending, 32'h0001_F800);
    link_valid = 1; link_data = 32'h800;
    alu_valid = 1; alu_dest = 8; alu_data = 32'h88;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_dest = 5'(11 + i); ld_data = 32'h100 + 32'(i);
      #1 chk("burst_busy", {link_ready, alu_ready}, 2'b00);
      tick();
      chk("burst_rdest", Rdest, 64'(11 + i));
      chk("burst_wdata", writeData, 64'(32'h100 + 32'(i)));
    end
    ld_valid = 0;
    #1 chk("starve_alu_rdy", alu_ready, 1);
    chk("starve_link_rdy", link_ready, 0);
    tick(); alu_valid = 0;
    chk("starve_alu_rdest", Rdest, 8);
    chk("starve_alu_wdata", writeData, 32'h88);
    #1 chk("late_link_rdy", link_ready, 1);
    tick(); link_valid = 0;
    chk("late_link_rdest", Rdest, 31);
    chk("late_link_wdata", writeData, 32'h800);
    chk("burst_pend", pending, 0);

    // Load-use stall on r7 through Rs, Rt and WAW, released the cycle after return.
    ld_issue = 1; ld_issue_dest = 7;
    tick(); ld_issue = 0; Rs = 7;
    #1 chk("use_rs_stall", issue_stall, 1);
    tick(); Rs = 0; Rt = 7;
    #1 chk("use_rt_stall", issue_stall, 1);
    Rt = 0; ld_issue = 1; ld_issue_dest = 7;
    #1 chk("waw_stall", issue_stall, 1);
    tick(); ld_issue = 0;
    chk("waw_pend", pending, 32'h80);
    Rs = 7; ld_valid = 1; ld_dest = 7; ld_data = 32'h77;
    #1 chk("ret_same_cyc", issue_stall, 1);
    tick(); ld_valid = 0;
    chk("ret_next_cyc", issue_stall, 0);
    chk("ret_pend", pending, 0);
    chk("ret_rdest", Rdest, 7);
    Rs = 0;

    // Same-index issue and return in one cycle: set wins.
    ld_issue = 1; ld_issue_dest = 9; ld_valid = 1; ld_dest = 9; ld_data = 32'h99;
    tick(); ld_issue = 0; ld_valid = 0;
    chk("setwins_pend", pending, 32'h200);
    ld_valid = 1; ld_dest = 9;
    tick(); ld_valid = 0;
    chk("clr9_pend", pending, 0);

    // r0: never pending, grant consumed without a write.
    ld_issue = 1; ld_issue_dest = 0;
    alu_valid = 1; alu_dest = 0; alu_data = 32'hDEAD;
    #1 chk("r0_stall", issue_stall, 0);
    chk("r0_alu_rdy", alu_ready, 1);
    tick(); ld_issue = 0; alu_valid = 0;
    chk("r0_pend", pending, 0);
    chk("r0_wen", regWriteEn, 0);

    // Asynchronous reset with r3 pending and a write on the port.
    ld_issue = 1; ld_issue_dest = 3;
    tick(); ld_issue = 0;
    chk("pend3", pending, 32'h8);
    alu_valid = 1; alu_dest = 4; alu_data = 32'h44;
    tick(); alu_valid = 0; Rs = 3;
    chk("inflight_wen", regWriteEn, 1);
    #1 chk("pre_rst_stall", issue_stall, 1);
    #1 reset = 0;
    #1 chk("arst_wen", regWriteEn, 0);
    chk("arst_pend", pending, 0);
    chk("arst_stall", issue_stall, 0);
    chk("arst_rdest", Rdest, 0);
    tick();
    reset = 1;
    tick();
    chk("post_rst_wen", regWriteEn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
